fp_accum: RTL and testbench
===========================

Name: fp_accum

Overview:
- Floating-point accumulator stage directly downstream of the fpMul multiplier in the convolution datapath.
- Sums KERNEL_SIZE consecutive half-precision products, one convolution window (default 3x3 = 9), into a single result.
- Presents the result on a valid/ready output for the activation/pooling stage.
- The datapath is a combinational FP adder plus an accumulator register. A two-state FSM handles counting and output hold.

Parameters:
- EXPONENT_WIDTH, 5, exponent field width (bias = 2^(EXPONENT_WIDTH-1)-1 = 15)
- MANTISSA_WIDTH, 10, stored fraction width (hidden 1 implied)
- KERNEL_SIZE, 9, number of products summed per output; legal range 1..255

Ports:
- clk, input, 1, rising-edge clock
- rst, input, 1, synchronous active-high reset
- in_valid, input, 1, in_data holds a product
- in_ready, output, 1, block can accept in_data this cycle
- in_data, input, EXPONENT_WIDTH+MANTISSA_WIDTH+1, product {sign, exponent, mantissa}
- out_valid, output, 1, out_data holds a finished window sum
- out_ready, input, 1, consumer accepts out_data this cycle
- out_data, output, EXPONENT_WIDTH+MANTISSA_WIDTH+1, accumulated sum

Behaviour:
- Interface: single clock clk. Reset rst is synchronous, active-high.
- Reset values (on any clk edge with rst=1):
  - state=ACCUM, count=0, accumulator=+0 (all zeros)
  - out_valid=0, out_data=0, in_ready=1
- rst has priority over all other events. Reset mid-window discards the partial sum.
- Transfer rules:
  - An input transfer is in_valid & in_ready.
  - An output transfer is out_valid & out_ready.
- FSM state ACCUM:
  - in_ready=1, out_valid=0.
  - On each input transfer: acc <= fp_add(acc, in_data), count <= count+1.
  - When the transfer makes count reach KERNEL_SIZE:
    - out_data <= fp_add(acc, in_data)
    - out_valid <= 1, acc <= +0, count <= 0
    - go to HOLD
  - Latency: out_valid rises on the edge that accepts the KERNEL_SIZE-th input, so it is visible the following cycle.
- FSM state HOLD:
  - in_ready=0, out_valid=1. out_data stays stable until an output transfer.
  - On an output transfer: out_valid <= 0, go to ACCUM.
  - No input is accepted in the same cycle. Throughput is at most 1 window per KERNEL_SIZE+1 cycles.
- in_valid=0 in ACCUM: no state change. Gaps between products are allowed.
- fp_add arithmetic:
  - Operand with exponent field 0 is treated as signed zero. There are no subnormals, and the mantissa is ignored.
  - Exponent 2^EXPONENT_WIDTH-1 (Inf/NaN) is treated as max finite, keeping its sign.
  - Swap operands so |A| >= |B|. Right-shift B's significand (hidden bit included) by the exponent difference.
    - A shift of MANTISSA_WIDTH+2 or more makes B contribute 0.
    - One guard bit is kept; it is discarded at the end.
  - Equal signs: add significands. A carry out gives shift right by 1, exponent +1.
  - Different signs: subtract. Leading-zero normalize left, decrementing the exponent.
  - Rounding is truncation (round toward zero).
  - Exact zero result gives +0 (0x0000).
  - Exponent underflow (<1) gives +0.
  - Overflow (exponent >= 2^EXPONENT_WIDTH-1) saturates to signed max finite: exponent 2^EXPONENT_WIDTH-2, mantissa all ones (0x7BFF / 0xFBFF).

Optional Feature:
- Macro: FP_ACCUM_BIAS_EN.
- Defined:
  - Adds input port bias (EXPONENT_WIDTH+MANTISSA_WIDTH+1 bits).
  - The accumulator is loaded with bias instead of +0 at reset and at each window start (the HOLD->ACCUM transition), so each output = bias + sum of products.
  - bias is sampled on that reset/transition edge.
- Undefined: no bias port; the accumulator starts from +0.

Decomposition:
- Package fp_pkg:
  - EXPONENT_WIDTH/MANTISSA_WIDTH defaults and derived FP_WIDTH, EXP_BIAS
  - constants FP_ZERO=16'h0000, FP_MAX_POS=16'h7BFF, FP_MAX_NEG=16'hFBFF
  - state enum {ACCUM, HOLD}
- One sub-module fp_add_comb: purely combinational half-precision adder implementing the fp_add rules above. It is reusable by later pooling/bias stages.
- fp_accum holds the FSM, the counter and the registers.

Test Plan:
- KERNEL_SIZE=3, out_ready=1; inputs 0x4B80 (15), 0x4E00 (24), 0xCE40 (-25) on consecutive cycles -> out_valid one cycle after the third input, out_data=0x4B00 (14), in_ready back to 1 after the transfer.
- KERNEL_SIZE=3; inputs 0x0000, 0x8000, 0x0000 -> out_data=0x0000 (+0). Then inputs 0x3C00, 0x1000 (2^-11), 0x0000 -> out_data=0x3C00 (truncation).
- KERNEL_SIZE=3; three inputs 0x7BFF -> out_data=0x7BFF (saturated). Three inputs 0xFBFF -> out_data=0xFBFF.
- Backpressure: complete a window, hold out_ready=0 for 3 cycles while in_valid=1 -> out_data stable, in_ready=0, no input consumed. Then out_ready=1 -> one transfer, and the next window accumulates correctly.
- Reset mid-window: KERNEL_SIZE=3; accept 0x4500, 0x4200, pulse rst for 1 cycle -> outputs at reset values. Then 0x3C00 x3 -> out_data=0x4200 (3.0).
- FP_ACCUM_BIAS_EN defined, bias=0x3C00, KERNEL_SIZE=3; inputs 0x4000 x3 (2.0) -> out_data=0x4700 (7.0).

Source files
------------

// File: rtl/fp_pkg.sv
// Shared half-precision definitions for the convolution datapath:
// default field widths, exponent bias, canonical constants and the
// accumulator FSM state type.
package fp_pkg;

  localparam int FP_EXP_WIDTH = 5;
  localparam int FP_MAN_WIDTH = 10;
  localparam int FP_WIDTH     = FP_EXP_WIDTH + FP_MAN_WIDTH + 1;
  localparam int EXP_BIAS     = (1 << (FP_EXP_WIDTH - 1)) - 1;

  localparam logic [15:0] FP_ZERO    = 16'h0000;
  localparam logic [15:0] FP_MAX_POS = 16'h7BFF;
  localparam logic [15:0] FP_MAX_NEG = 16'hFBFF;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/fp_add_comb.sv
// Combinational floating-point adder, no subnormals, one guard bit,
// truncating rounding and saturation to max finite on overflow.
// Exponent-zero operands are signed zero; all-ones exponents (Inf/NaN)
// are clamped to max finite with their sign.
module fp_add_comb #(
  parameter int EXPONENT_WIDTH = 5,
  parameter int MANTISSA_WIDTH = 10
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] sum
);

  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int W  = EW + MW + 1;
  localparam logic [EW-1:0] EXP_ONES = {EW{1'b1}};
  localparam logic [EW-1:0] EXP_MAXF = {{(EW-1){1'b1}}, 1'b0};

  logic          sign_a, sign_b, sign_l, sign_s;
  logic [EW-1:0] exp_a, exp_b, exp_l, exp_s;
  logic [MW:0]   sig_a, sig_b, sig_l, sig_s;
  logic [MW+1:0] al_l, al_s;
  logic [MW+2:0] raw;
  int            diff_i, exp_i, lz;

  // unpack, align the smaller operand, add/subtract, normalize, pack
  always_comb begin
    sign_a = a[W-1];
    exp_a  = a[W-2:MW];
    sig_a  = {1'b1, a[MW-1:0]};
    if (exp_a == '0) begin
      sig_a = '0;
    end else if (exp_a == EXP_ONES) begin
      exp_a = EXP_MAXF;
      sig_a = '1;
    end
    sign_b = b[W-1];
    exp_b  = b[W-2:MW];
    sig_b  = {1'b1, b[MW-1:0]};
    if (exp_b == '0) begin
      sig_b = '0;
    end else if (exp_b == EXP_ONES) begin
      exp_b = EXP_MAXF;
      sig_b = '1;
    end

    // larger magnitude becomes the reference operand
    if ({exp_b, sig_b} > {exp_a, sig_a}) begin
      sign_l = sign_b; exp_l = exp_b; sig_l = sig_b;
      sign_s = sign_a; exp_s = exp_a; sig_s = sig_a;
    end else begin
      sign_l = sign_a; exp_l = exp_a; sig_l = sig_a;
      sign_s = sign_b; exp_s = exp_b; sig_s = sig_b;
    end

    diff_i = int'(exp_l) - int'(exp_s);
    exp_i  = int'(exp_l);
    al_l   = {sig_l, 1'b0};
    if (diff_i >= MW + 2) al_s = '0;
    else                  al_s = {sig_s, 1'b0} >> diff_i;

    lz = 0;
    if (sign_l == sign_s) begin
      raw = {1'b0, al_l} + {1'b0, al_s};
      if (raw[MW+2]) begin
        raw   = raw >> 1;
        exp_i = exp_i + 1;
      end
    end else begin
      raw = {1'b0, al_l - al_s};
      // highest set bit wins because the scan runs upward
      for (int i = 0; i <= MW + 1; i++) begin
        if (raw[i]) lz = MW + 1 - i;
      end
      raw   = raw << lz;
      exp_i = exp_i - lz;
    end

    if (raw == '0 || exp_i < 1) begin
      sum = '0;
    end else if (exp_i >= (1 << EW) - 1) begin
      sum = {sign_l, EXP_MAXF, {MW{1'b1}}};
    end else begin
      sum = {sign_l, exp_i[EW-1:0], raw[MW:1]};
    end
  end

endmodule

// File: rtl/fp_accum.sv
// Window accumulator behind the FP multiplier: sums KERNEL_SIZE products
// and offers the result on a valid/ready port. While a result is held no
// new product is accepted.
// Optional macro FP_ACCUM_BIAS_EN adds a bias port that seeds the
// accumulator at reset and at every window start.
module fp_accum
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH = FP_EXP_WIDTH,
  parameter int MANTISSA_WIDTH = FP_MAN_WIDTH,
  parameter int KERNEL_SIZE    = 9
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_data
`ifdef FP_ACCUM_BIAS_EN
  ,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] bias
`endif
);

  localparam int W = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam logic [7:0] LAST_COUNT = 8'(KERNEL_SIZE - 1);

  state_t         state_reg;
  logic [7:0]     count_reg;
  logic [W-1:0]   acc_reg;
  logic [W-1:0]   out_data_reg;
  logic           out_valid_reg;
  logic           in_ready_reg;
  logic [W-1:0]   sum_next;
  logic [W-1:0]   acc_init;

`ifdef FP_ACCUM_BIAS_EN
  assign acc_init = bias;
`else
  assign acc_init = '0;
`endif

  fp_add_comb #(
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .MANTISSA_WIDTH(MANTISSA_WIDTH)
  ) u_add (
    .a  (acc_reg),
    .b  (in_data),
    .sum(sum_next)
  );

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  // window FSM: accumulate products, then hold the result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACCUM;
      count_reg     <= '0;
      acc_reg       <= acc_init;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (in_valid) begin
            if (count_reg == LAST_COUNT) begin
              out_data_reg  <= sum_next;
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
              acc_reg       <= '0;
              count_reg     <= '0;
              state_reg     <= HOLD;
            end else begin
              acc_reg   <= sum_next;
              count_reg <= count_reg + 8'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            acc_reg       <= acc_init;
            state_reg     <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum.sv
// Self-checking bench for fp_accum with a 3-product window. An integer
// model of the adder and window behaviour runs alongside the DUT and is
// compared every cycle; directed windows also carry literal expectations.
module tb_fp_accum;

  localparam int KS = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] bias_val;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  fp_accum #(.KERNEL_SIZE(KS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef FP_ACCUM_BIAS_EN
    ,
    .bias     (bias_val)
`endif
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // value-level model of one addition: scaled integers, exact sum then truncation
  function automatic int fexp(input logic [15:0] x);
    if (x[14:10] == 5'd31) return 30;
    return int'(x[14:10]);
  endfunction

  function automatic int fsig(input logic [15:0] x);
    if (x[14:10] == 5'd0) return 0;
    if (x[14:10] == 5'd31) return 2047;
    return 1024 + int'(x[9:0]);
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] l, s;
    int el, es, d, p, e;
    longint vl, vs, tot, m, mant;
    logic [4:0] e5;
    logic [9:0] m10;
    if (fexp(b) * 4096 + fsig(b) > fexp(a) * 4096 + fsig(a)) begin
      l = b; s = a;
    end else begin
      l = a; s = b;
    end
    el = fexp(l);
    es = fexp(s);
    d  = el - es;
    vl = longint'(fsig(l)) * 2;
    vs = (d >= 12) ? 0 : ((longint'(fsig(s)) * 2) >> d);
    tot = (l[15] ? -vl : vl) + (s[15] ? -vs : vs);
    if (tot == 0) return 16'h0000;
    m = (tot < 0) ? -tot : tot;
    p = 0;
    for (int i = 0; i < 40; i++) if (((m >> i) & 1) == 1) p = i;
    e = el + p - 11;
    if (e < 1) return 16'h0000;
    if (e >= 31) return {tot < 0, 5'd30, 10'h3FF};
    mant = (p >= 10) ? (m >> (p - 10)) : (m << (10 - p));
    e5  = e[4:0];
    m10 = mant[9:0];
    return {tot < 0, e5, m10};
  endfunction

  logic        m_hold;
  int          m_cnt;
  logic [15:0] m_acc;
  logic [15:0] m_out;
  logic [15:0] m_init;

`ifdef FP_ACCUM_BIAS_EN
  assign m_init = bias_val;
`else
  assign m_init = 16'h0000;
`endif

  // window model: counts accepted products, holds the sum until taken
  always @(posedge clk) begin
    if (rst) begin
      m_hold <= 1'b0;
      m_cnt  <= 0;
      m_acc  <= m_init;
      m_out  <= 16'h0000;
    end else if (!m_hold) begin
      if (in_valid) begin
        if (m_cnt == KS - 1) begin
          m_out  <= model_add(m_acc, in_data);
          m_hold <= 1'b1;
          m_cnt  <= 0;
          m_acc  <= 16'h0000;
        end else begin
          m_acc <= model_add(m_acc, in_data);
          m_cnt <= m_cnt + 1;
        end
      end
    end else if (out_ready) begin
      m_hold <= 1'b0;
      m_acc  <= m_init;
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {15'd0, in_ready}, {15'd0, !m_hold});
      check("out_valid", {15'd0, out_valid}, {15'd0, m_hold});
      if (m_hold) check("out_data", out_data, m_out);
    end
  end

  task automatic push(input logic [15:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 16'd0, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_window(input string name, input logic [15:0] lit);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, {15'd0, out_valid}, 16'd1);
    check(name, out_data, lit);
    check({name, "_model"}, m_out, lit);
    $display("window %s: out_data=%h expected %h", name, out_data, lit);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1; bias_val = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    chk_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);

    // 15 + 24 - 25 = 14, result visible right after the third accept
    push(16'h4B80); push(16'h4E00); push(16'hCE40);
    check("lat_valid", {15'd0, out_valid}, 16'd1);
    expect_window("sum14", 16'h4B00);
    @(negedge clk);
    check("ready_back", {15'd0, in_ready}, 16'd1);

    // signed zeros, then truncation of a tiny addend
    push(16'h0000); push(16'h8000); push(16'h0000);
    expect_window("zeros", 16'h0000);
    push(16'h3C00); push(16'h1000); push(16'h0000);
    expect_window("trunc", 16'h3C00);

    // saturation both signs
    push(16'h7BFF); push(16'h7BFF); push(16'h7BFF);
    expect_window("sat_pos", 16'h7BFF);
    push(16'hFBFF); push(16'hFBFF); push(16'hFBFF);
    expect_window("sat_neg", 16'hFBFF);

    // cancellation with idle gaps: 3 - 3 - 1 = -1
    push(16'h4200); @(negedge clk); push(16'hC200); repeat (2) @(negedge clk); push(16'hBC00);
    expect_window("cancel", 16'hBC00);

    // backpressure: result held, products offered but refused
    @(negedge clk);
    out_ready = 1'b0;
    push(16'h4500); push(16'h4200); push(16'h3C00);
    in_valid = 1'b1; in_data = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      check("bp_data", out_data, 16'h4880);
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released", {15'd0, out_valid}, 16'd0);
    push(16'h4000); push(16'h4000); push(16'h4000);
    expect_window("after_bp", 16'h4600);

    // reset in the middle of a window drops the partial sum
    @(negedge clk);
    push(16'h4500); push(16'h4200);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", {15'd0, in_ready}, 16'd1);
    check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
    check("mid_rst_data", out_data, 16'h0000);
    rst = 1'b0;
    push(16'h3C00); push(16'h3C00); push(16'h3C00);
    expect_window("post_rst", 16'h4200);

`ifdef FP_ACCUM_BIAS_EN
    // bias seeded at reset: 1 + 2 + 2 + 2 = 7
    @(negedge clk);
    bias_val = 16'h3C00;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    push(16'h4000); push(16'h4000); push(16'h4000);
    expect_window("bias", 16'h4700);
    @(negedge clk);
    push(16'h4000); push(16'h4000); push(16'h4000);
    expect_window("bias_again", 16'h4700);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
